// File: rtl/rx78_kbd.sv
// rx78_kbd: PS/2 key events into the RX-78 9x8 key matrix, read back through port F4
module rx78_kbd #(
   parameter int HOLD_CYCLES = 200000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic        io_sel,
   input  logic        io_wr,
   input  logic [7:0]  io_din,
   output logic [7:0]  io_dout
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(HOLD_CYCLES + 1);
   logic            toggle_d, ev;
   logic            s1_v, s1_press, s1_ext;
   logic [7:0]      s1_code, lk;
   logic            s2_v, s2_press;
   logic [3:0]      s2_row;
   logic [2:0]      s2_col;
   logic [8:0][7:0] matrix, mat_n;
   logic [TW-1:0]   timer;
   logic [6:0]      mem [FIFO_DEPTH];
   logic [AW:0]     wp, rp;
   logic [6:0]      head;
   logic            full, pop, push, bypass, press;
   logic [7:0]      strobe, any_row, rd;

   function automatic logic [7:0] k(input int r, input int c);
      return {1'b1, 4'(r), 3'(c)};
   endfunction

   assign ev = ps2_key[10] ^ toggle_d;

   always_comb begin
      lk = 8'h00;
      case ({s1_ext, s1_code})
         9'h045: lk = k(1, 0);  9'h016: lk = k(1, 1);  9'h01E: lk = k(1, 2);  9'h026: lk = k(1, 3);
         9'h025: lk = k(1, 4);  9'h02E: lk = k(1, 5);  9'h036: lk = k(1, 6);  9'h03D: lk = k(1, 7);
         9'h03E: lk = k(2, 0);  9'h046: lk = k(2, 1);  9'h052: lk = k(2, 2);  9'h04C: lk = k(2, 3);
         9'h041: lk = k(2, 4);  9'h04E: lk = k(2, 5);  9'h049: lk = k(2, 6);  9'h04A: lk = k(2, 7);
         9'h054: lk = k(3, 0);  9'h01C: lk = k(3, 1);  9'h032: lk = k(3, 2);  9'h021: lk = k(3, 3);
         9'h023: lk = k(3, 4);  9'h024: lk = k(3, 5);  9'h02B: lk = k(3, 6);  9'h034: lk = k(3, 7);
         9'h033: lk = k(4, 0);  9'h043: lk = k(4, 1);  9'h03B: lk = k(4, 2);  9'h042: lk = k(4, 3);
         9'h04B: lk = k(4, 4);  9'h03A: lk = k(4, 5);  9'h031: lk = k(4, 6);  9'h044: lk = k(4, 7);
         9'h04D: lk = k(5, 0);  9'h015: lk = k(5, 1);  9'h02D: lk = k(5, 2);  9'h01B: lk = k(5, 3);
         9'h02C: lk = k(5, 4);  9'h03C: lk = k(5, 5);  9'h02A: lk = k(5, 6);  9'h01D: lk = k(5, 7);
         9'h022: lk = k(6, 0);  9'h035: lk = k(6, 1);  9'h01A: lk = k(6, 2);  9'h05B: lk = k(6, 3);
         9'h05D: lk = k(6, 4);  9'h05A: lk = k(7, 0);  9'h066: lk = k(7, 1);  9'h029: lk = k(8, 0);
         9'h00D: lk = k(8, 1);  9'h175: lk = k(8, 2);  9'h172: lk = k(8, 3);  9'h16B: lk = k(8, 4);
         9'h174: lk = k(8, 5);  9'h012: lk = k(0, 0);  9'h059: lk = k(0, 0);  9'h014: lk = k(0, 1);
         9'h076: lk = k(0, 2);
         default: lk = 8'h00;
      endcase
   end

   assign full   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop    = (timer == '0) && (wp != rp);
   assign press  = s2_v & s2_press;
   assign push   = s2_v & ~s2_press & ~full;
   assign bypass = s2_v & ~s2_press & full;
   assign head   = mem[rp[AW-1:0]];

   always_comb begin
      mat_n = matrix;
      if (pop) mat_n[head[6:3]][head[2:0]] = 1'b0;
      if (bypass) mat_n[s2_row][s2_col] = 1'b0;
      if (press) mat_n[s2_row][s2_col] = 1'b1;
   end

   always_comb begin
      any_row = 8'h00;
      for (int i = 0; i < 9; i++) any_row = any_row | matrix[i];
   end

   assign rd = (strobe inside {[8'd1:8'd9]}) ? matrix[4'(strobe - 8'd1)] :
               (strobe == 8'h30) ? any_row : 8'h00;

   always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= {s2_row, s2_col};

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         toggle_d <= ps2_key[10];
         s1_v     <= 1'b0;
         s1_press <= 1'b0;
         s1_ext   <= 1'b0;
         s1_code  <= 8'h00;
         s2_v     <= 1'b0;
         s2_press <= 1'b0;
         s2_row   <= 4'd0;
         s2_col   <= 3'd0;
         matrix   <= '0;
         timer    <= '0;
         wp       <= '0;
         rp       <= '0;
         strobe   <= 8'h00;
         io_dout  <= 8'h00;
      end else begin
         toggle_d <= ps2_key[10];
         s1_v     <= ev;
         if (ev) {s1_press, s1_ext, s1_code} <= ps2_key[9:0];
         s2_v     <= s1_v & lk[7];
         s2_press <= s1_press;
         s2_row   <= lk[6:3];
         s2_col   <= lk[2:0];
         matrix   <= mat_n;
         timer    <= press ? TW'(HOLD_CYCLES) : (timer != '0) ? timer - TW'(1) : timer;
         wp       <= wp + {{AW{1'b0}}, push};
         rp       <= rp + {{AW{1'b0}}, pop};
         if (io_sel & io_wr) strobe <= io_din;
         io_dout  <= rd;
      end
endmodule

// File: tb/tb_rx78_kbd.sv
// tb_rx78_kbd: randomized and directed stimulus, per-cycle scoreboard against a key-level model
`timescale 1ns/1ps
module tb_rx78_kbd;
   localparam int H = 100, D = 4;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] ps2_key;
   logic        io_sel, io_wr;
   logic [7:0]  io_din, io_dout;
   int          cyc, dl, errors, checks;
   bit          mm [9][8];
   int          rq [$];
   typedef struct {int at; bit press; int k;} ev_t;
   ev_t         pend [$];
   logic [7:0]  sb [$];
   logic        tg_m;
   logic [7:0]  st_m;
   logic [8:0]  pool [9] = '{9'h01C, 9'h029, 9'h05A, 9'h175, 9'h012, 9'h059, 9'h07E, 9'h075, 9'h11C};

   rx78_kbd #(.HOLD_CYCLES(H), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .io_sel(io_sel),
      .io_wr(io_wr), .io_din(io_din), .io_dout(io_dout)
   );

   always #5 clk = ~clk;

   function automatic int map(logic e, logic [7:0] c);
      if (e) return (c == 8'h75) ? 66 : -1;
      case (c)
         8'h1C: return 25;
         8'h29: return 64;
         8'h5A: return 56;
         8'h12, 8'h59: return 0;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] model_rd();
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8; j++)
            if (mm[i][j] && ((st_m >= 1 && st_m <= 9 && i == st_m - 1) || st_m == 8'h30)) r[j] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         foreach (mm[i, j]) mm[i][j] = 1'b0;
         rq.delete();
         pend.delete();
         sb.delete();
         dl = 0;
         st_m = 8'h00;
         tg_m = ps2_key[10];
      end else begin
         bit  was_full;
         int  k;
         ev_t e;
         cyc++;
         sb.push_back(model_rd());
         if (io_sel && io_wr) st_m = io_din;
         was_full = rq.size() == D;
         if (cyc >= dl && rq.size() > 0) begin
            k = rq.pop_front();
            mm[k / 8][k % 8] = 1'b0;
         end
         if (pend.size() > 0 && pend[0].at == cyc) begin
            e = pend.pop_front();
            if (e.press) begin
               mm[e.k / 8][e.k % 8] = 1'b1;
               dl = cyc + H + 1;
            end else if (was_full) mm[e.k / 8][e.k % 8] = 1'b0;
            else rq.push_back(e.k);
         end
         if (ps2_key[10] != tg_m) begin
            k = map(ps2_key[8], ps2_key[7:0]);
            if (k >= 0) pend.push_back('{cyc + 2, ps2_key[9], k});
         end
         tg_m = ps2_key[10];
      end
   end

   always @(negedge clk) if (reset_n && sb.size() > 0) begin
      logic [7:0] e;
      e = sb.pop_front();
      checks++;
      if (io_dout !== e) begin
         errors++;
         $display("FAIL scoreboard cyc=%0d io_dout=%h expected=%h", cyc, io_dout, e);
      end
   end

   task automatic chk(string n, logic [7:0] exp);
      checks++;
      if (io_dout !== exp) begin
         errors++;
         $display("FAIL %s io_dout=%h expected=%h", n, io_dout, exp);
      end
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic key(bit p, bit e, logic [7:0] c);
      @(negedge clk);
      ps2_key = {~ps2_key[10], p, e, c};
   endtask

   task automatic wr(logic [7:0] v);
      @(negedge clk);
      io_sel = 1'b1; io_wr = 1'b1; io_din = v;
      @(negedge clk);
      io_sel = 1'b0; io_wr = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d expected=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int op, ki;
      logic [7:0] v;
      reset_n = 1'b0; ps2_key = '0; io_sel = 1'b0; io_wr = 1'b0; io_din = 8'h00;
      idle(3);
      reset_n = 1'b1;
      wr(8'h04); key(1, 0, 8'h1C); idle(4); chk("press_a_row3", 8'h02);
      wr(8'h30); idle(2); chk("press_a_or", 8'h02);
      key(0, 0, 8'h1C); idle(150); chk("release_a", 8'h00);
      wr(8'h09); key(1, 0, 8'h29); idle(9); key(0, 0, 8'h29);
      idle(50); chk("tap_held", 8'h01);
      idle(60); chk("tap_drained", 8'h00);
      key(1, 1, 8'h75); idle(4); chk("ext_up", 8'h04);
      key(1, 0, 8'h75); idle(4); chk("nonext_75", 8'h04);
      key(0, 1, 8'h75); idle(120); chk("up_drained", 8'h00);
      key(1, 0, 8'h1C); idle(2); key(1, 0, 8'h29); idle(2); key(1, 0, 8'h5A); idle(2);
      key(1, 1, 8'h75); idle(2); key(1, 0, 8'h12); idle(2);
      wr(8'h30); idle(4); chk("five_or", 8'h07);
      wr(8'h01); idle(2); chk("shift_row0", 8'h01);
      key(0, 0, 8'h1C); key(0, 0, 8'h29); key(0, 0, 8'h5A); key(0, 1, 8'h75); key(0, 0, 8'h12);
      idle(4); chk("overflow_bypass", 8'h00);
      wr(8'h09); idle(2); chk("queued_held", 8'h05);
      idle(120); chk("queue_drained", 8'h00);
      key(1, 0, 8'h1C); key(1, 0, 8'h29);
      wr(8'h00); idle(2); chk("strobe_00", 8'h00);
      wr(8'h0A); idle(2); chk("strobe_0a", 8'h00);
      wr(8'hFF); idle(2); chk("strobe_ff", 8'h00);
      wr(8'h30); idle(2); chk("strobe_30", 8'h03);
      key(1, 0, 8'h7E); idle(4); chk("unmapped_7e", 8'h03);
      key(1, 1, 8'h1C); idle(4); chk("unmapped_e01c", 8'h03);
      wr(8'h04); idle(2); chk("row3_a", 8'h02);
      wr(8'h30); key(1, 0, 8'h5A); @(posedge clk); #2 reset_n = 1'b0;
      #1 chk("async_reset", 8'h00);
      @(negedge clk); reset_n = 1'b1;
      idle(3); chk("strobe_reset", 8'h00);
      key(1, 0, 8'h1C); idle(4); chk("strobe_zero_after_reset", 8'h00);
      wr(8'h30); idle(2); chk("inflight_lost", 8'h02);
      repeat (300) begin
         op = $urandom_range(0, 9);
         ki = $urandom_range(0, 8);
         if (op <= 3) key(1, pool[ki][8], pool[ki][7:0]);
         else if (op <= 6) key(0, pool[ki][8], pool[ki][7:0]);
         else if (op == 7) begin
            v = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 9)) : 8'h30;
            wr(v);
         end else if (op == 8) begin
            @(negedge clk);
            io_sel = $urandom_range(0, 1) == 1; io_wr = ~io_sel; io_din = 8'($urandom);
            @(negedge clk);
            io_sel = 1'b0; io_wr = 1'b0;
         end else idle($urandom_range(0, 130));
      end
      idle(140);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
